mipi_rx_byte_aligner_nlane: RTL and testbench

Multi-lane successor to the single-lane MIPI D-PHY HS byte aligner. It sits between the per-lane deserialisers and the CSI-2 lane merger. It searches each lane independently for the HS sync byte at any bit offset, then locks and re-slices each lane's payload. It deskews lanes that lock on different cycles and flags soft sync errors, sync timeouts and skew overflow.

---
 rtl/mipi_rx_byte_aligner_nlane_pkg.sv | 14 +
 rtl/mipi_rx_byte_aligner_nlane_lane_aligner.sv | 71 +++++++
 rtl/mipi_rx_byte_aligner_nlane.sv | 103 ++++++++++
 tb/tb_mipi_rx_byte_aligner_nlane.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mipi_rx_byte_aligner_nlane_pkg.sv
// Shared constants, state encodings and helpers for the multi-lane HS byte aligner.
// Default sync byte and lane data width live here for every aligner file.
package mipi_rx_byte_aligner_nlane_pkg;
  localparam int         LANE_W        = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

  typedef enum logic {LN_SEARCH, LN_LOCKED} lane_st_e;
  typedef enum logic {G_WAIT_ALL, G_STREAM} glb_st_e;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    popcnt8 = '0;
    for (int i = 0; i < 8; i++) popcnt8 = popcnt8 + {3'b000, v[i]};
  endfunction
endpackage

// File: rtl/mipi_rx_byte_aligner_nlane_lane_aligner.sv
// One lane: sync search over all 8 bit offsets, offset freeze on lock, payload re-slice.
module mipi_rx_lane_aligner
  import mipi_rx_byte_aligner_nlane_pkg::*;
#(
  parameter logic [LANE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [LANE_W-1:0] byte_i,
  output logic              locked_o,
  output logic              soft_err_o,
  output logic [LANE_W-1:0] payload_o
);
  localparam int OW = $clog2(LANE_W);

  lane_st_e            st_q;
  logic [LANE_W-1:0]   prev_q;
  logic [OW-1:0]       off_q;
  logic                soft_q;
  logic [2*LANE_W-1:0] win;
  logic                ex_hit, sb_hit;
  logic [OW-1:0]       ex_k, sb_k;

  assign win = {byte_i, prev_q};

  // Scan from the top offset down so the lowest matching offset is the one kept.
  always_comb begin
    ex_hit = 1'b0;
    sb_hit = 1'b0;
    ex_k   = '0;
    sb_k   = '0;
    for (int k = LANE_W - 1; k >= 0; k--) begin
      if (win[k +: LANE_W] == SYNC_BYTE) begin
        ex_hit = 1'b1;
        ex_k   = OW'(k);
      end
      if (popcnt8(win[k +: LANE_W] ^ SYNC_BYTE) == 4'd1) begin
        sb_hit = 1'b1;
        sb_k   = OW'(k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      st_q   <= LN_SEARCH;
      prev_q <= '0;
      off_q  <= '0;
      soft_q <= 1'b0;
    end else begin
      prev_q <= byte_i;
      case (st_q)
        LN_SEARCH: begin
          if (ex_hit) begin
            st_q  <= LN_LOCKED;
            off_q <= ex_k;
          end else if (sb_hit) begin
            st_q   <= LN_LOCKED;
            off_q  <= sb_k;
            soft_q <= 1'b1;
          end
        end
        default: st_q <= LN_LOCKED;
      endcase
    end
  end

  assign locked_o   = (st_q == LN_LOCKED);
  assign soft_err_o = soft_q;
  assign payload_o  = win[off_q +: LANE_W];
endmodule

// File: rtl/mipi_rx_byte_aligner_nlane.sv
// N-lane HS byte aligner: per-lane aligners, deskew FIFOs, stream gating, sticky error flags.
module mipi_rx_byte_aligner_nlane
  import mipi_rx_byte_aligner_nlane_pkg::*;
#(
  parameter int         LANES     = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_SKEW  = 2,
  parameter int         TIMEOUT   = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [LANE_W*LANES-1:0]   byte_i,
  output logic [LANE_W*LANES-1:0]   byte_o,
  output logic                      byte_valid_o,
  output logic [LANES-1:0]          lane_locked_o,
  output logic                      sot_err_soft_o,
  output logic                      timeout_err_o,
  output logic                      skew_err_o
);
  localparam int DEPTH = MAX_SKEW + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [LANES-1:0][LANE_W-1:0]            pay;
  logic [LANES-1:0]                        lane_lk, lane_soft;
  logic [LANES-1:0][DEPTH-1:0][LANE_W-1:0] mem_q;
  logic [LANES-1:0][PW-1:0]                rptr_q, wptr_q, rnx, wnx;
  logic [LANES-1:0][CW-1:0]                cnt_q, cnt_d;
  logic [LANES-1:0]                        full, do_wr, ovf;
  glb_st_e                                 st_q;
  logic                                    skew_q, tmo_q, pop, all_lk, all_ne_d;
  logic [15:0]                             tmr_q, tmr_d;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    mipi_rx_lane_aligner #(.SYNC_BYTE(SYNC_BYTE)) u_lane (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .byte_i     (byte_i[LANE_W*n +: LANE_W]),
      .locked_o   (lane_lk[n]),
      .soft_err_o (lane_soft[n]),
      .payload_o  (pay[n])
    );
  end

  // Once skew has overflowed the lanes can no longer be trusted to line up.
  assign pop    = (st_q == G_STREAM) && !skew_q;
  assign all_lk = &lane_lk;
  assign tmr_d  = (&tmr_q) ? tmr_q : tmr_q + 16'd1;

  always_comb begin
    full     = '0;
    do_wr    = '0;
    ovf      = '0;
    cnt_d    = cnt_q;
    rnx      = rptr_q;
    wnx      = wptr_q;
    all_ne_d = 1'b1;
    byte_o   = '0;
    for (int n = 0; n < LANES; n++) begin
      full[n]  = (cnt_q[n] == CW'(DEPTH));
      do_wr[n] = lane_lk[n] && (!full[n] || pop);
      ovf[n]   = lane_lk[n] && full[n] && !pop;
      cnt_d[n] = cnt_q[n] + CW'(do_wr[n]) - CW'(pop);
      if (cnt_d[n] == '0) all_ne_d = 1'b0;
      wnx[n]   = (wptr_q[n] == PW'(DEPTH - 1)) ? '0 : wptr_q[n] + 1'b1;
      rnx[n]   = (rptr_q[n] == PW'(DEPTH - 1)) ? '0 : rptr_q[n] + 1'b1;
      if (pop) byte_o[LANE_W*n +: LANE_W] = mem_q[n][rptr_q[n]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      st_q   <= G_WAIT_ALL;
      skew_q <= 1'b0;
      tmo_q  <= 1'b0;
      tmr_q  <= '0;
      mem_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      tmr_q <= tmr_d;
      if ((tmr_d >= 16'(TIMEOUT)) && !all_lk) tmo_q <= 1'b1;
      if (|ovf) skew_q <= 1'b1;
      // Enter streaming as soon as the last lane's first byte lands in its FIFO.
      if ((st_q == G_WAIT_ALL) && all_lk && all_ne_d) st_q <= G_STREAM;
      cnt_q <= cnt_d;
      for (int n = 0; n < LANES; n++) begin
        if (do_wr[n]) begin
          mem_q[n][wptr_q[n]] <= pay[n];
          wptr_q[n]           <= wnx[n];
        end
        if (pop) rptr_q[n] <= rnx[n];
      end
    end
  end

  assign byte_valid_o   = pop;
  assign lane_locked_o  = lane_lk;
  assign sot_err_soft_o = |lane_soft;
  assign timeout_err_o  = tmo_q;
  assign skew_err_o     = skew_q;
endmodule

// File: tb/tb_mipi_rx_byte_aligner_nlane.sv
// Directed scenarios with a scoreboard queue; a negedge monitor checks every valid word.
module tb_mipi_rx_byte_aligner_nlane;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] byte_i;
  logic [15:0] byte_o;
  logic        byte_valid_o, sot_err_soft_o, timeout_err_o, skew_err_o;
  logic [1:0]  lane_locked_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  logic [7:0] S1  [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h25, 8'h42, 8'hCE, 8'h22};
  logic [7:0] S2  [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h70, 8'h41, 8'hA0, 8'h22, 8'h72};
  logic [7:0] S3  [4]  = '{8'h00, 8'hB9, 8'h11, 8'h22};
  logic [7:0] S4A [8]  = '{8'h00, 8'h77, 8'h25, 8'h42, 8'hCE, 8'h22, 8'h00, 8'h00};
  logic [7:0] S4B [8]  = '{8'h00, 8'h00, 8'h00, 8'h77, 8'h25, 8'h42, 8'hCE, 8'h22};
  logic [7:0] S5A [9]  = '{8'h00, 8'h77, 8'h25, 8'h42, 8'hCE, 8'h22, 8'h00, 8'h00, 8'h00};
  logic [7:0] S5B [9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h25, 8'h42, 8'hCE};

  always #5 clk = ~clk;

  mipi_rx_byte_aligner_nlane #(
    .LANES(2), .SYNC_BYTE(8'hB8), .MAX_SKEW(2), .TIMEOUT(16)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .byte_i         (byte_i),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .lane_locked_o  (lane_locked_o),
    .sot_err_soft_o (sot_err_soft_o),
    .timeout_err_o  (timeout_err_o),
    .skew_err_o     (skew_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (byte_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word got=%0h want=none", byte_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word", {16'h0, byte_o}, {16'h0, mon_e});
      end
    end
  end

  task automatic drive(input logic [7:0] l0, input logic [7:0] l1);
    byte_i = {l1, l0};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    byte_i  = '0;
    @(posedge clk);
    #1;
    chk(tag, {10'h0, byte_valid_o, lane_locked_o, sot_err_soft_o, timeout_err_o, skew_err_o, byte_o}, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_s1();
    exp_q.push_back(16'h2B2B);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h7272);
    exp_q.push_back(16'h1616);
    for (int i = 0; i < 10; i++) begin
      drive(S1[i], S1[i]);
      if (i == 5) chk("s1_lock", {29'h0, lane_locked_o, byte_valid_o}, {29'h0, 2'b11, 1'b0});
      if (i == 6) chk("s1_valid_rise", {31'h0, byte_valid_o}, 32'h1);
    end
    chk("s1_soft", {31'h0, sot_err_soft_o}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    byte_i  = '0;
    do_reset("rst_init");

    run_s1();
    do_reset("rst_midstream");

    exp_q.push_back(16'h2020);
    exp_q.push_back(16'h5050);
    exp_q.push_back(16'h1111);
    for (int i = 0; i < 10; i++) drive(S2[i], S2[i]);
    chk("s2_soft", {31'h0, sot_err_soft_o}, 32'h0);
    do_reset("rst_s2");

    exp_q.push_back(16'h1111);
    for (int i = 0; i < 4; i++) drive(S3[i], S3[i]);
    chk("s3_soft", {31'h0, sot_err_soft_o}, 32'h1);
    chk("s3_lock", {30'h0, lane_locked_o}, 32'h3);
    do_reset("rst_s3");

    exp_q.push_back(16'h2B2B);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h7272);
    exp_q.push_back(16'h1616);
    for (int i = 0; i < 8; i++) drive(S4A[i], S4B[i]);
    chk("s4_skew", {31'h0, skew_err_o}, 32'h0);
    chk("s4_valid", {31'h0, byte_valid_o}, 32'h1);
    do_reset("rst_s4");

    for (int i = 0; i < 9; i++) begin
      drive(S5A[i], S5B[i]);
      if (i == 4) chk("s5_skew_before", {31'h0, skew_err_o}, 32'h0);
      if (i == 5) chk("s5_skew_rise", {31'h0, skew_err_o}, 32'h1);
    end
    chk("s5_end", {29'h0, lane_locked_o, byte_valid_o}, {29'h0, 2'b11, 1'b0});
    do_reset("rst_s5");

    for (int i = 0; i < 15; i++) drive(8'h00, 8'h00);
    chk("tmo_before", {31'h0, timeout_err_o}, 32'h0);
    drive(8'h00, 8'h00);
    chk("tmo_at16", {31'h0, timeout_err_o}, 32'h1);
    do_reset("rst_tmo");

    run_s1();
    do_reset("rst_final");

    repeat (3) drive(8'h00, 8'h00);
    chk("sb_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
